// File: rtl/fa4_mem_arbiter.sv
// Two-port round-robin arbiter for a single-port memory. Each granted
// transaction spends one cycle in ACCESS driving the memory and one cycle
// in DONE pulsing ack, so a port can complete at most one access every
// three cycles.
`timescale 1ns/1ps
module fa4_mem_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic [1:0]    req,
    input  logic [1:0]    wr,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q;
    logic          last_q;   // port granted most recently; resets to 1 so port 0 wins first tie
    logic          win_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          win_d;

    // Pick the winner among current requests; a tie goes to the port not granted last.
    always_comb begin
        win_d = 1'b0;
        unique case (req)
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = ~last_q;
            default: win_d = 1'b0;
        endcase
    end

    // Controller: latch the winning request in IDLE, capture read data at the end of ACCESS.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        win_q   <= win_d;
                        last_q  <= win_d;
                        wr_q    <= win_d ? wr[1] : wr[0];
                        addr_q  <= win_d ? addr1 : addr0;
                        wdata_q <= win_d ? wdata1 : wdata0;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (!wr_q) begin
                        rdata_q <= mem_rdata;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state, so req never reaches mem_* combinationally.
    always_comb begin
        busy      = (state_q != StIdle);
        grant     = busy ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        ack       = (state_q == StDone) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        mem_re    = (state_q == StAccess) && !wr_q;
        mem_we    = (state_q == StAccess) && wr_q;
        mem_oe    = mem_we;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_fa4_mem_arbiter.sv
// Self-checking bench for fa4_mem_arbiter: directed scenarios plus random
// traffic checked against a transaction-level round-robin/memory model.
`timescale 1ns/1ps
module tb_fa4_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] wr = '0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0] ack, grant;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       busy, mem_re, mem_we, mem_oe;

    // Memory device seen by the DUT
    logic [7:0] mem [256];
    assign mem_rdata = mem_oe ? mem_wdata : mem[mem_addr];
    always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Reference model state: expected memory contents, last granted port, held read data
    logic [7:0] mem_m [256];
    int         last_m;
    logic [7:0] rdata_m;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    fa4_mem_arbiter #(.DW(8), .AW(8)) dut (
        .clock(clock), .reset_L(reset_L), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
    );

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction from IDLE; nr is the req value left driven after ack.
    task automatic run_txn(input logic [1:0] r, input logic [1:0] w,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] nr, input string name);
        int p;
        logic [7:0] ea, ed;
        logic ew;
        req = r; wr = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        if (r == 2'b11) p = (last_m == 0) ? 1 : 0;
        else            p = (r == 2'b10) ? 1 : 0;
        ea = (p == 1) ? a1 : a0;
        ed = (p == 1) ? d1 : d0;
        ew = w[p];
        step();
        total++;
        if ({busy, grant, ack} !== {1'b1, oh(p), 2'b00}) $display("FAIL %s access-grant: got busy/grant/ack=%b/%b/%b required 1/%b/00", name, busy, grant, ack, oh(p));
        else passed++;
        total++;
        if ({mem_re, mem_we, mem_oe, mem_addr} !== {~ew, ew, ew, ea}) $display("FAIL %s access-mem: got re/we/oe/addr=%b%b%b/%h required %b%b%b/%h", name, mem_re, mem_we, mem_oe, mem_addr, ~ew, ew, ew, ea);
        else passed++;
        if (ew) begin
            total++;
            if (mem_wdata !== ed) $display("FAIL %s wdata: got %h required %h", name, mem_wdata, ed);
            else passed++;
        end
        last_m = p;
        if (ew) mem_m[ea] = ed;
        else    rdata_m = mem_m[ea];
        step();
        total++;
        if ({ack, grant, mem_re, mem_we, mem_oe} !== {oh(p), oh(p), 3'b000}) $display("FAIL %s done: got ack/grant/en=%b/%b/%b%b%b required %b/%b/000", name, ack, grant, mem_re, mem_we, mem_oe, oh(p), oh(p));
        else passed++;
        total++;
        if (rdata !== rdata_m) $display("FAIL %s rdata: got %h required %h", name, rdata, rdata_m);
        else passed++;
        req = nr;
        step();
        total++;
        if ({busy, ack, grant} !== 5'b0) $display("FAIL %s idle: got busy/ack/grant=%b/%b/%b required 0/00/00", name, busy, ack, grant);
        else passed++;
    endtask

    task automatic do_reset();
        req = '0;
        reset_L = 1'b0;
        step();
        step();
        reset_L = 1'b1;
        last_m  = 1;
        rdata_m = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ack, grant, busy, mem_re, mem_we, mem_oe} !== 8'b0) $display("FAIL reset-ctrl: got ack/grant/busy/re/we/oe=%b/%b/%b%b%b%b required all 0", ack, grant, busy, mem_re, mem_we, mem_oe);
        else passed++;
        total++;
        if ({mem_addr, mem_wdata, rdata} !== 24'h0) $display("FAIL reset-data: got addr/wdata/rdata=%h/%h/%h required 00/00/00", mem_addr, mem_wdata, rdata);
        else passed++;
    endtask

    task automatic test_read();
        run_txn(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b00, "read_p0");
    endtask

    task automatic test_write();
        run_txn(2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h3C, 2'b00, "write_p1");
        run_txn(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 2'b00, "readback_p0");
    endtask

    task automatic test_tie();
        do_reset();
        run_txn(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, "tie_first");
        run_txn(2'b10, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, "tie_second");
    endtask

    task automatic test_back_to_back();
        int p;
        req = 2'b11; wr = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if (mem_re && mem_we) $display("FAIL b2b re_we: got re=1 we=1 required not both at cycle %0d", c);
            else passed++;
            if (c % 3 == 2) begin
                p = (last_m == 0) ? 1 : 0;
                last_m = p;
                rdata_m = mem_m[(p == 1) ? 8'h20 : 8'h10];
                total++;
                if (ack !== oh(p) || rdata !== rdata_m) $display("FAIL b2b ack: got ack/rdata=%b/%h required %b/%h at cycle %0d", ack, rdata, oh(p), rdata_m, c);
                else passed++;
            end else begin
                total++;
                if (ack !== 2'b00) $display("FAIL b2b quiet: got ack=%b required 00 at cycle %0d", ack, c);
                else passed++;
            end
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_addr_change();
        req = 2'b01; wr = 2'b00; addr0 = 8'h10;
        step();
        addr0 = 8'h55;
        req = 2'b00;
        #1;
        total++;
        if ({mem_re, mem_addr} !== {1'b1, 8'h10}) $display("FAIL addr_change access: got re/addr=%b/%h required 1/10", mem_re, mem_addr);
        else passed++;
        last_m = 0;
        rdata_m = mem_m[8'h10];
        step();
        total++;
        if (ack !== 2'b01 || rdata !== rdata_m) $display("FAIL addr_change done: got ack/rdata=%b/%h required 01/%h", ack, rdata, rdata_m);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        req = 2'b01; wr = 2'b01; addr0 = 8'h30; wdata0 = 8'h77;
        step();
        total++;
        if (mem_we !== 1'b1) $display("FAIL reset_mid pre: got we=%b required 1", mem_we);
        else passed++;
        #2 reset_L = 1'b0;
        #1;
        total++;
        if ({busy, grant, mem_we, mem_oe, mem_re, mem_addr, rdata} !== 21'b0) $display("FAIL reset_mid async: got busy/grant/we/oe/re=%b/%b/%b%b%b addr/rdata=%h/%h required zeros", busy, grant, mem_we, mem_oe, mem_re, mem_addr, rdata);
        else passed++;
        req = 2'b00; wr = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (ack !== 2'b00) $display("FAIL reset_mid ack: got %b required 00", ack);
            else passed++;
        end
        total++;
        if (mem[8'h30] !== mem_m[8'h30]) $display("FAIL reset_mid mem30: got %h required %h", mem[8'h30], mem_m[8'h30]);
        else passed++;
        reset_L = 1'b1;
        last_m  = 1;
        rdata_m = 8'h00;
        step();
    endtask

    task automatic test_random();
        logic [1:0] r, w;
        for (int i = 0; i < 24; i++) begin
            r = 2'($urandom_range(1, 3));
            w = 2'($urandom_range(0, 3));
            run_txn(r, w, 8'h40 + 8'($urandom_range(0, 7)), 8'h40 + 8'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 2'b00, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            mem_m[i] = 8'h00;
        end
        mem[8'h10]   = 8'hA5;
        mem_m[8'h10] = 8'hA5;
        last_m  = 1;
        rdata_m = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_back_to_back();
        test_addr_change();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fa4_mem_arbiter.md
Name: fa4_mem_arbiter

Overview:
Two-port round-robin arbiter that shares the single-port Memory (re/we, combinational read, posedge write) between the instruction-fetch unit (port 0) and the load/store unit (port 1).
Each request/ack transaction performs exactly one read or one write.
The block owns the memory control lines and address, drives write data onto the bus through an output-enable, and returns registered read data to the winning port.

Parameters:
DW, 8, data width of the memory word
AW, 8, address width of the memory

Ports:
clock  input  1  system clock
reset_L  input  1  reset; asynchronous, active-low
req  input  2  per-port request; bit i = port i
wr  input  2  per-port op select: 1 = write, 0 = read; valid while req[i]=1
addr0  input  AW  port 0 address
addr1  input  AW  port 1 address
wdata0  input  DW  port 0 write data
wdata1  input  DW  port 1 write data
ack  output  2  one-cycle completion pulse, one-hot
rdata  output  DW  read data, valid while ack[i]=1 and the op was a read
grant  output  2  one-hot owner during ACCESS and DONE; 0 in IDLE
busy  output  1  1 when state != IDLE
mem_re  output  1  memory read enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  data to drive onto the memory Data bus
mem_oe  output  1  tristate enable for mem_wdata (top level drives Data = mem_oe ? mem_wdata : 'z)
mem_rdata  input  DW  memory Data bus as seen by the arbiter

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=IDLE; ack=0, grant=0, busy=0, mem_re=0, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0, rdata=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE. All outputs except busy are registered or decoded from registered state; no combinational path from req to mem_*.
- IDLE:
  - If any req bit is set at the posedge, select the winner, latch {winner, wr, addr, wdata} into internal registers, and go to ACCESS.
  - If only one port requests, that port wins.
  - If both request, the port != last_grant wins; last_grant updates to the winner.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - Read: mem_re=1, mem_we=0, mem_oe=0; rdata register captures mem_rdata at the posedge ending ACCESS.
  - Write: mem_we=1, mem_oe=1, mem_re=0, mem_wdata = latched data; Memory commits at that same posedge.
  - Then go to DONE.
- DONE (1 cycle):
  - ack[winner]=1, grant holds, all mem_* enables 0.
  - rdata holds the captured value until the next read capture; rdata is unchanged by writes.
  - Always returns to IDLE.
- Latency and throughput:
  - req seen at posedge N → ACCESS in cycle N+1 → ack in cycle N+2.
  - Minimum 3 cycles per transaction; back-to-back from one port = one access every 3 cycles.
- Requester protocol:
  - Hold req, wr, addr, wdata stable until ack is sampled.
  - Drop req in the cycle after ack, or keep it high to issue a new transaction.
- Protocol violations:
  - Inputs are sampled only in IDLE, so changes to req, wr, addr or wdata after grant do not affect the in-flight access.
  - A withdrawn req does not cancel the access; ack still pulses.
- Starvation: under continuous requests from both ports, grants strictly alternate 0,1,0,1.
- Reset mid-operation (ACCESS or DONE):
  - Immediate return to IDLE with all outputs at reset values; no ack is issued.
  - A write in ACCESS whose posedge has not occurred is not performed.
- Invariants: mem_re & mem_we never both 1; mem_oe == mem_we; ack and grant are one-hot or zero.

Test Plan:
- Reset, then req=2'b01, wr=0, addr0=8'h10, memory[8'h10]=8'hA5 → mem_re=1 and mem_addr=8'h10 in cycle N+1; ack=2'b01 and rdata=8'hA5 in cycle N+2.
- Port 1 write: req=2'b10, wr=2'b10, addr1=8'h20, wdata1=8'h3C → mem_we=1, mem_oe=1, mem_wdata=8'h3C in ACCESS; ack=2'b10; a following port 0 read of 8'h20 returns 8'h3C.
- First tie after reset: req=2'b11 → grant=2'b01 first; port 0 drops req after ack; port 1 is granted in the next IDLE→ACCESS.
- Both ports hold req=2'b11 for 12 cycles → ack sequence 01,10,01,10 at 3-cycle spacing; mem_re and mem_we never both high.
- Change addr0 from 8'h10 to 8'h55 during ACCESS → mem_addr stays 8'h10; ack still pulses.
- Assert reset_L=0 mid-ACCESS on a write to 8'h30 (old value 8'h00) → outputs cleared asynchronously, no ack; memory[8'h30] remains 8'h00.
